axi4_mem_arbiter: RTL
=====================

// Module: axi4_mem_arbiter
// PURPOSE
//  Shares a single AXI4-lite word-addressed memory slave (axi4_memory) between two masters: m0 = PicoRV32 core, m1 = host/loader port.
//  Grants one complete transaction (read or write) at a time; round-robin on contention. Addresses >= ADDR_LIMIT are terminated
//  locally with a decode-error response, so an out-of-range access never stalls on the slave. Sits between the masters and the memory.
// PARAMETERS
//  ADDR_LIMIT    1144          first illegal word address; equals memory depth (MEMORY_SIZE-8)
//  DEFAULT_RDATA 32'hDEAD_BEEF rdata returned on a decode-error read
// PORTS (N in {0,1}; every mN_ line is instanced once per master)
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  mN_axi_aw{valid,ready,addr,prot}  in/out/in/in   1/1/32/3  write address channel from master N
//  mN_axi_w{valid,ready,data,strb}   in/out/in/in   1/1/32/4  write data channel from master N
//  mN_axi_b{valid,ready}             out/in         1/1       write response to master N
//  mN_axi_ar{valid,ready,addr,prot}  in/out/in/in   1/1/32/3  read address channel from master N
//  mN_axi_r{valid,ready,data}        out/in/out     1/1/32    read data to master N
//  s_axi_*        mirror   same channels toward the memory slave (directions inverted)
//  grant          out  1   master owning the current/last transaction
//  decerr         out  1   sticky; set on any out-of-range access, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, every valid/ready output 0, grant=1 (m0 wins the first tie), decerr=0, aw_done=w_done=0.
//  Request: reqN = mN_arvalid | mN_awvalid | mN_wvalid. FSM decides in IDLE only; the chosen master is forwarded starting the next cycle.
//  Arbitration: a single requester wins. If both request, the winner is !grant (alternates). Within a master, write wins over read.
//  States: IDLE -> RD_A | WR_AW (in range) or ERR_RD | ERR_WR (out of range, addr = araddr/awaddr sampled in IDLE).
//   RD_A: s_ar* = granted m_ar*, m_arready = s_arready; on s AR handshake -> RD_R.
//   RD_R: m_rvalid/rdata = s_r*, s_rready = m_rready; on R handshake -> IDLE.
//   WR_AW: AW and W forwarded independently; aw_done/w_done set on their handshakes (both may complete in one cycle);
//          once both set, ready for that channel drops to 0; -> WR_B when both done.
//   WR_B: m_bvalid = s_bvalid, s_bready = m_bready; on B handshake -> IDLE, clear aw_done/w_done.
//   ERR_RD: assert m_arready 1 cycle, then m_rvalid=1, rdata=DEFAULT_RDATA until rready; -> IDLE; decerr<=1. Slave untouched.
//   ERR_WR: accept AW and W (any order, ready 1 cycle each), then m_bvalid until bready; -> IDLE; decerr<=1. Memory unmodified.
//  Non-granted master: all readies and r/b valids held 0; its valids and payload are ignored and must remain stable (AXI rule).
//  All s_* valids are 0 outside the matching state; no combinational path from mN valid to s valid in IDLE.
//  Latency: 1 cycle IDLE->forward, plus slave latency; back-to-back transactions pass through IDLE (min 1 bubble per transaction).
//  Fairness: with continuous requests from both masters, grants strictly alternate; no master waits more than one transaction.
//  Addr compare: unsigned 32-bit, addr >= ADDR_LIMIT is out of range; prot is forwarded unchanged and never inspected.
//  Reset mid-transaction: FSM returns to IDLE and drops all valids immediately; the slave must be reset in the same cycle.
// STRUCTURE
//  Shared include axi4_arb_defs.vh: state encodings (IDLE, RD_A, RD_R, WR_AW, WR_B, ERR_RD, ERR_WR), ADDR_LIMIT default.
//  Sub-module rr_arbiter2: req[1:0], last grant, advance strobe -> one-hot grant; registered last-grant pointer.
//  Channel steering is a grant-indexed mux/demux in the top level; no FIFOs, one transaction outstanding.
// TESTING
//  1 m0 read addr 5 alone (mem[5]=32'h1234) -> m0 rdata 32'h1234, m1 sees no rvalid, grant=0.
//  2 m0 and m1 raise arvalid in the same cycle after reset -> m0 served first, then m1; 4 more rounds strictly alternate.
//  3 m1 write addr 10 data 32'hAABBCCDD strb 4'b0101, W presented 3 cycles before AW -> one B; mem[10] = old with bytes 0,2 updated.
//  4 m0 read addr 1144 -> rdata 32'hDEADBEEF, decerr=1, s_arvalid never asserted; next in-range read proceeds normally.
//  5 m0 write pending while m1 read pending, grant=0 -> m1 read granted first, then m0 write; slave never sees both at once.
//  6 reset asserted during RD_R with rvalid pending -> next cycle all valids 0, state IDLE, grant=1, decerr=0.

Source files
------------

// File: rtl/axi4_mem_arbiter_pkg.sv
// Shared types and defaults for the two-master AXI4-lite memory arbiter.
package axi4_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AW  = 3'd3,
    ST_WR_B   = 3'd4,
    ST_ERR_RD = 3'd5,
    ST_ERR_WR = 3'd6
  } arb_state_t;

  // First illegal word address (memory depth) and the read data for decode errors.
  localparam logic [31:0] ADDR_LIMIT_DEF    = 32'd1144;
  localparam logic [31:0] DEFAULT_RDATA_DEF = 32'hDEAD_BEEF;

  // Unsigned 32-bit range test; anything at or above the limit is a decode error.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/axi4_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the master
// that did not win last time. The pointer moves only on the advance strobe.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       last_o
);

  logic last_q;
  logic last_d;

  // One-hot grant from the request pair and the last-grant pointer.
  always_comb begin
    gnt_o  = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (adv_i && (gnt_o != 2'b00)) last_d = gnt_o[1];
  end

  // Last-grant pointer; resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/axi4_mem_arbiter.sv
// Shares one AXI4-lite memory slave between two masters, one whole transaction
// at a time. Out-of-range addresses are answered locally with a decode error.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1; a source holds valid and payload stable until then,
// and valid never waits on ready.
module axi4_mem_arbiter
  import axi4_mem_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT    = ADDR_LIMIT_DEF,
  parameter logic [31:0] DEFAULT_RDATA = DEFAULT_RDATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_axi_awvalid, output logic m0_axi_awready,
  input  logic [31:0] m0_axi_awaddr,  input  logic [2:0] m0_axi_awprot,
  input  logic        m0_axi_wvalid,  output logic m0_axi_wready,
  input  logic [31:0] m0_axi_wdata,   input  logic [3:0] m0_axi_wstrb,
  output logic        m0_axi_bvalid,  input  logic m0_axi_bready,
  input  logic        m0_axi_arvalid, output logic m0_axi_arready,
  input  logic [31:0] m0_axi_araddr,  input  logic [2:0] m0_axi_arprot,
  output logic        m0_axi_rvalid,  input  logic m0_axi_rready,
  output logic [31:0] m0_axi_rdata,
  input  logic        m1_axi_awvalid, output logic m1_axi_awready,
  input  logic [31:0] m1_axi_awaddr,  input  logic [2:0] m1_axi_awprot,
  input  logic        m1_axi_wvalid,  output logic m1_axi_wready,
  input  logic [31:0] m1_axi_wdata,   input  logic [3:0] m1_axi_wstrb,
  output logic        m1_axi_bvalid,  input  logic m1_axi_bready,
  input  logic        m1_axi_arvalid, output logic m1_axi_arready,
  input  logic [31:0] m1_axi_araddr,  input  logic [2:0] m1_axi_arprot,
  output logic        m1_axi_rvalid,  input  logic m1_axi_rready,
  output logic [31:0] m1_axi_rdata,
  output logic        s_axi_awvalid,  input  logic s_axi_awready,
  output logic [31:0] s_axi_awaddr,   output logic [2:0] s_axi_awprot,
  output logic        s_axi_wvalid,   input  logic s_axi_wready,
  output logic [31:0] s_axi_wdata,    output logic [3:0] s_axi_wstrb,
  input  logic        s_axi_bvalid,   output logic s_axi_bready,
  output logic        s_axi_arvalid,  input  logic s_axi_arready,
  output logic [31:0] s_axi_araddr,   output logic [2:0] s_axi_arprot,
  input  logic        s_axi_rvalid,   output logic s_axi_rready,
  input  logic [31:0] s_axi_rdata,
  output logic        grant,
  output logic        decerr,
  output logic [2:0]  dbg_state
);

  arb_state_t  state_q;
  logic        aw_done_q, w_done_q, ar_done_q, decerr_q;
  logic [1:0]  req, gnt_oh;
  logic        adv, g;
  logic        c_awv, c_wv, c_is_wr, c_hold, c_oor;
  logic [31:0] c_addr;
  logic        sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic        g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req = {m1_axi_arvalid | m1_axi_awvalid | m1_axi_wvalid,
                m0_axi_arvalid | m0_axi_awvalid | m0_axi_wvalid};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req),
    .adv_i  (adv),
    .gnt_o  (gnt_oh),
    .last_o (g)
  );

  // Candidate decode in IDLE. A write whose AW has not shown up yet (W first)
  // is held in IDLE so the range check always sees a valid awaddr.
  always_comb begin
    c_awv   = gnt_oh[1] ? m1_axi_awvalid : m0_axi_awvalid;
    c_wv    = gnt_oh[1] ? m1_axi_wvalid  : m0_axi_wvalid;
    c_is_wr = c_awv | c_wv;
    c_hold  = c_is_wr & ~c_awv;
    c_addr  = c_is_wr ? (gnt_oh[1] ? m1_axi_awaddr : m0_axi_awaddr)
                      : (gnt_oh[1] ? m1_axi_araddr : m0_axi_araddr);
    c_oor   = ~addr_in_range(c_addr, ADDR_LIMIT);
    adv     = (state_q == ST_IDLE) && (req != 2'b00) && !c_hold;
  end

  // Steering toward the slave from the granted master; slave valids only in their state.
  always_comb begin
    sel_awvalid   = g ? m1_axi_awvalid : m0_axi_awvalid;
    sel_wvalid    = g ? m1_axi_wvalid  : m0_axi_wvalid;
    sel_bready    = g ? m1_axi_bready  : m0_axi_bready;
    sel_arvalid   = g ? m1_axi_arvalid : m0_axi_arvalid;
    sel_rready    = g ? m1_axi_rready  : m0_axi_rready;
    s_axi_awaddr  = g ? m1_axi_awaddr  : m0_axi_awaddr;
    s_axi_awprot  = g ? m1_axi_awprot  : m0_axi_awprot;
    s_axi_wdata   = g ? m1_axi_wdata   : m0_axi_wdata;
    s_axi_wstrb   = g ? m1_axi_wstrb   : m0_axi_wstrb;
    s_axi_araddr  = g ? m1_axi_araddr  : m0_axi_araddr;
    s_axi_arprot  = g ? m1_axi_arprot  : m0_axi_arprot;
    s_axi_awvalid = (state_q == ST_WR_AW) & sel_awvalid & ~aw_done_q;
    s_axi_wvalid  = (state_q == ST_WR_AW) & sel_wvalid & ~w_done_q;
    s_axi_bready  = (state_q == ST_WR_B) & sel_bready;
    s_axi_arvalid = (state_q == ST_RD_A) & sel_arvalid;
    s_axi_rready  = (state_q == ST_RD_R) & sel_rready;
  end

  // Responses for the granted master, either from the slave or generated locally on decode error.
  always_comb begin
    g_arready = ((state_q == ST_RD_A) & s_axi_arready) | ((state_q == ST_ERR_RD) & ~ar_done_q);
    g_rvalid  = ((state_q == ST_RD_R) & s_axi_rvalid)  | ((state_q == ST_ERR_RD) & ar_done_q);
    g_awready = ((state_q == ST_WR_AW) & s_axi_awready & ~aw_done_q) | ((state_q == ST_ERR_WR) & ~aw_done_q);
    g_wready  = ((state_q == ST_WR_AW) & s_axi_wready & ~w_done_q)   | ((state_q == ST_ERR_WR) & ~w_done_q);
    g_bvalid  = ((state_q == ST_WR_B) & s_axi_bvalid)  | ((state_q == ST_ERR_WR) & aw_done_q & w_done_q);
    aw_hs = sel_awvalid & g_awready;
    w_hs  = sel_wvalid & g_wready;
    b_hs  = g_bvalid & sel_bready;
    ar_hs = sel_arvalid & g_arready;
    r_hs  = g_rvalid & sel_rready;
    m0_axi_awready = ~g & g_awready;  m1_axi_awready = g & g_awready;
    m0_axi_wready  = ~g & g_wready;   m1_axi_wready  = g & g_wready;
    m0_axi_bvalid  = ~g & g_bvalid;   m1_axi_bvalid  = g & g_bvalid;
    m0_axi_arready = ~g & g_arready;  m1_axi_arready = g & g_arready;
    m0_axi_rvalid  = ~g & g_rvalid;   m1_axi_rvalid  = g & g_rvalid;
    m0_axi_rdata   = (state_q == ST_ERR_RD) ? DEFAULT_RDATA : s_axi_rdata;
    m1_axi_rdata   = m0_axi_rdata;
  end

  // Transaction FSM: decide in IDLE, run one transaction, return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
      decerr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (adv) begin
          if (c_oor) decerr_q <= 1'b1;
          if (c_is_wr) state_q <= c_oor ? ST_ERR_WR : ST_WR_AW;
          else         state_q <= c_oor ? ST_ERR_RD : ST_RD_A;
        end
        ST_RD_A: if (ar_hs) state_q <= ST_RD_R;
        ST_RD_R: if (r_hs)  state_q <= ST_IDLE;
        ST_WR_AW: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_q <= ST_WR_B;
        end
        ST_WR_B: if (b_hs) begin
          state_q   <= ST_IDLE;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        ST_ERR_RD: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (r_hs) begin
            state_q   <= ST_IDLE;
            ar_done_q <= 1'b0;
          end
        end
        ST_ERR_WR: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (b_hs) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = g;
  assign decerr    = decerr_q;
  assign dbg_state = state_q;

endmodule
